// File: rtl/ascon_in_fifo_pkg.sv
//==============================================================================
// Package : ascon_pack
// Brief   : Bus/block widths and big-endian beat packing for the Ascon input FIFOs.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package ascon_pack;

  localparam int BusWidth   = 32;
  localparam int BlockWidth = 64;

  // Ascon is big-endian: the first beat on the bus lands in the upper half.
  function automatic logic [BlockWidth-1:0] pack_be(input logic [BusWidth-1:0] hi,
                                                    input logic [BusWidth-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_in_fifo_word_packer.sv
//==============================================================================
// Module  : word_packer
// Brief   : Pairs 32-bit beats into 64-bit blocks; holds the first beat until its pair.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module word_packer
  import ascon_pack::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [BusWidth-1:0]   beat,
  input  logic                  accept,
  input  logic                  flush,
  output logic                  blk_valid,
  output logic [BlockWidth-1:0] blk,
  output logic                  half
);

  logic [BusWidth-1:0] r_hold;
  logic                r_half;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hold <= '0;
      r_half <= 1'b0;
    end else if (flush) begin
      r_half <= 1'b0;
    end else if (accept) begin
      if (!r_half) begin
        r_hold <= beat;
      end
      r_half <= ~r_half;
    end
  end

  // A completed block is written in the same edge that accepts the second beat.
  assign blk_valid = accept & r_half & ~flush;
  assign blk       = pack_be(r_hold, beat);
  assign half      = r_half;

endmodule

`default_nettype wire

// File: rtl/ascon_in_fifo.sv
//==============================================================================
// Module  : ascon_in_fifo
// Brief   : Beat-packing FWFT input FIFO feeding the Ascon core's AD or PT port.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module ascon_in_fifo
  import ascon_pack::*;
#(
  parameter int Depth     = 16,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic                  half_o,
  input  logic                  flush_i,
  input  logic                  pop_i,
  output logic [BlockWidth-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [AddrWidth:0]    level_o
);

  localparam logic [AddrWidth:0] c_full_level = (AddrWidth+1)'(Depth);

  logic [BlockWidth-1:0] r_mem [Depth];
  logic [AddrWidth-1:0]  r_wr_ptr;
  logic [AddrWidth-1:0]  r_rd_ptr;
  logic [AddrWidth:0]    r_level;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_blk_valid;
  logic [BlockWidth-1:0] w_blk;

  assign w_full   = (r_level == c_full_level);
  assign w_empty  = (r_level == '0);
  // Both beats stall while full, so a completed pair always has a free slot.
  assign w_accept = wvalid_i & ~w_full;
  assign w_pop    = pop_i & ~w_empty;

  word_packer u_packer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .beat      (wdata_i),
    .accept    (w_accept),
    .flush     (flush_i),
    .blk_valid (w_blk_valid),
    .blk       (w_blk),
    .half      (half_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_blk_valid) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_blk_valid, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the level counter.
  always_ff @(posedge clk_i) begin
    if (w_blk_valid) begin
      r_mem[r_wr_ptr] <= w_blk;
    end
  end

  assign data_o   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign wready_o = ~w_full;
  assign empty_o  = w_empty;
  assign full_o   = w_full;
  assign level_o  = r_level;

endmodule

`default_nettype wire

// File: tb/tb_ascon_in_fifo.sv
//==============================================================================
// Module  : tb_ascon_in_fifo
// Brief   : Directed self-checking bench for ascon_in_fifo.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module tb_ascon_in_fifo;

  logic        clk;
  logic        rst_n;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        half;
  logic        flush;
  logic        pop;
  logic [63:0] data;
  logic        empty;
  logic        full;
  logic [4:0]  level;

  int checks = 0;
  int passed = 0;

  ascon_in_fifo #(.Depth(16)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .wdata_i  (wdata),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .half_o   (half),
    .flush_i  (flush),
    .pop_i    (pop),
    .data_o   (data),
    .empty_o  (empty),
    .full_o   (full),
    .level_o  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic p);
    wvalid = 1'b1;
    wdata  = d;
    pop    = p;
    step();
    wvalid = 1'b0;
    pop    = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (level !== 5'd0) $display("FAIL reset_level got %0d exp 0", level); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
    checks++; if (half !== 1'b0) $display("FAIL reset_half got %b exp 0", half); else passed++;
    checks++; if (wready !== 1'b1) $display("FAIL reset_wready got %b exp 1", wready); else passed++;
    checks++; if (data !== 64'h0) $display("FAIL reset_data got %h exp 0", data); else passed++;
  endtask

  task automatic test_pack();
    send(32'h01234567, 1'b0);
    checks++; if (half !== 1'b1) $display("FAIL pack_half1 got %b exp 1", half); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL pack_empty1 got %b exp 1", empty); else passed++;
    send(32'h89ABCDEF, 1'b0);
    checks++; if (empty !== 1'b0) $display("FAIL pack_empty2 got %b exp 0", empty); else passed++;
    checks++; if (level !== 5'd1) $display("FAIL pack_level got %0d exp 1", level); else passed++;
    checks++; if (half !== 1'b0) $display("FAIL pack_half2 got %b exp 0", half); else passed++;
    checks++; if (data !== 64'h0123456789ABCDEF) $display("FAIL pack_data got %h exp 0123456789abcdef", data); else passed++;
    do_pop();
    checks++; if (empty !== 1'b1) $display("FAIL pack_pop_empty got %b exp 1", empty); else passed++;
    checks++; if (data !== 64'h0) $display("FAIL pack_pop_data got %h exp 0", data); else passed++;
  endtask

  task automatic test_fill_stall();
    do_flush();
    for (int i = 0; i < 32; i++) send(32'(i), 1'b0);
    checks++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else passed++;
    checks++; if (level !== 5'd16) $display("FAIL fill_level got %0d exp 16", level); else passed++;
    checks++; if (wready !== 1'b0) $display("FAIL fill_wready got %b exp 0", wready); else passed++;
    checks++; if (data !== {32'd0, 32'd1}) $display("FAIL fill_head got %h exp 0000000000000001", data); else passed++;
    wvalid = 1'b1;
    wdata  = 32'hAAAA0001;
    repeat (3) step();
    checks++; if (half !== 1'b0) $display("FAIL stall_half got %b exp 0", half); else passed++;
    checks++; if (level !== 5'd16) $display("FAIL stall_level got %0d exp 16", level); else passed++;
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (level !== 5'd15) $display("FAIL stall_pop_level got %0d exp 15", level); else passed++;
    checks++; if (wready !== 1'b1) $display("FAIL stall_pop_wready got %b exp 1", wready); else passed++;
    checks++; if (half !== 1'b0) $display("FAIL stall_pop_half got %b exp 0", half); else passed++;
    step();
    wvalid = 1'b0;
    checks++; if (half !== 1'b1) $display("FAIL stall_accept_half got %b exp 1", half); else passed++;
    checks++; if (level !== 5'd15) $display("FAIL stall_accept_level got %0d exp 15", level); else passed++;
    checks++; if (data !== {32'd2, 32'd3}) $display("FAIL stall_head got %h exp 0000000200000003", data); else passed++;
    do_flush();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 5; k++) begin
      send(32'h5000_0000 + 32'(k), 1'b0);
      send(32'h6000_0000 + 32'(k), 1'b0);
    end
    for (int k = 0; k < 5; k++) do_pop();
    for (int k = 0; k < 16; k++) begin
      send(32'hC000_0000 + 32'(k), 1'b0);
      send(32'hD000_0000 + 32'(k), 1'b0);
    end
    checks++; if (full !== 1'b1) $display("FAIL wrap_full got %b exp 1", full); else passed++;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (data !== {32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k)})
        $display("FAIL wrap_order[%0d] got %h exp %h%h", k, data, 32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k));
      else passed++;
      do_pop();
    end
    checks++; if (empty !== 1'b1) $display("FAIL wrap_empty got %b exp 1", empty); else passed++;
  endtask

  task automatic test_simultaneous();
    do_flush();
    send(32'hA0A0A0A0, 1'b0);
    send(32'hA1A1A1A1, 1'b1);
    checks++; if (level !== 5'd1) $display("FAIL sim0_level got %0d exp 1", level); else passed++;
    checks++; if (data !== 64'hA0A0A0A0A1A1A1A1) $display("FAIL sim0_data got %h exp a0a0a0a0a1a1a1a1", data); else passed++;
    send(32'hB0B0B0B0, 1'b0);
    send(32'hB1B1B1B1, 1'b0);
    send(32'hC0C0C0C0, 1'b0);
    send(32'hC1C1C1C1, 1'b0);
    checks++; if (level !== 5'd3) $display("FAIL sim3_pre_level got %0d exp 3", level); else passed++;
    send(32'hD0D0D0D0, 1'b0);
    send(32'hD1D1D1D1, 1'b1);
    checks++; if (level !== 5'd3) $display("FAIL sim3_level got %0d exp 3", level); else passed++;
    checks++; if (data !== 64'hB0B0B0B0B1B1B1B1) $display("FAIL sim3_data got %h exp b0b0b0b0b1b1b1b1", data); else passed++;
  endtask

  task automatic test_flush_half();
    do_flush();
    send(32'h11111111, 1'b0);
    checks++; if (half !== 1'b1) $display("FAIL flush_pre_half got %b exp 1", half); else passed++;
    flush  = 1'b1;
    wvalid = 1'b1;
    wdata  = 32'h22222222;
    step();
    flush  = 1'b0;
    wvalid = 1'b0;
    checks++; if (half !== 1'b0) $display("FAIL flush_half got %b exp 0", half); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL flush_level got %0d exp 0", level); else passed++;
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b0);
    checks++; if (level !== 5'd1) $display("FAIL flush_new_level got %0d exp 1", level); else passed++;
    checks++; if (data !== 64'h3333333344444444) $display("FAIL flush_new_data got %h exp 3333333344444444", data); else passed++;
  endtask

  task automatic test_async_reset();
    do_flush();
    for (int k = 0; k < 5; k++) begin
      send(32'hE000_0000 + 32'(k), 1'b0);
      send(32'hF000_0000 + 32'(k), 1'b0);
    end
    send(32'h77777777, 1'b0);
    checks++; if (level !== 5'd5) $display("FAIL arst_pre_level got %0d exp 5", level); else passed++;
    checks++; if (half !== 1'b1) $display("FAIL arst_pre_half got %b exp 1", half); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 5'd0) $display("FAIL arst_level got %0d exp 0", level); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL arst_empty got %b exp 1", empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL arst_full got %b exp 0", full); else passed++;
    checks++; if (half !== 1'b0) $display("FAIL arst_half got %b exp 0", half); else passed++;
    checks++; if (wready !== 1'b1) $display("FAIL arst_wready got %b exp 1", wready); else passed++;
    checks++; if (data !== 64'h0) $display("FAIL arst_data got %h exp 0", data); else passed++;
    #2;
    rst_n = 1'b1;
    step();
    checks++; if (level !== 5'd0) $display("FAIL arst_post_level got %0d exp 0", level); else passed++;
  endtask

  initial begin
    rst_n  = 1'b0;
    wdata  = '0;
    wvalid = 1'b0;
    flush  = 1'b0;
    pop    = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_pack();
    test_fill_stall();
    test_wrap();
    test_simultaneous();
    test_flush_half();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
